// File: rtl/codec_init_sequencer.sv
// WM8731 configuration sequencer: writes the 11-word init table through an I2C
// master request/done handshake, retries NACKed words, then serves volume writes.
module codec_init_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         MAX_RETRY      = 3,
    parameter int         POST_RESET_DLY = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        vol_update,
    input  logic [6:0]  volume,
    output logic        i2c_req,
    output logic [6:0]  i2c_addr,
    output logic [15:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  reg_index
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int DLY_W   = (POST_RESET_DLY < 2) ? 1 : $clog2(POST_RESET_DLY);
    localparam logic [3:0]  LAST_INDEX = 4'd10;
    localparam logic [15:0] VOL_BASE   = 16'h0500;  // R2, LRHPBOTH=1, LZCEN=0

    typedef enum logic [3:0] {
        IDLE, ISSUE, WAIT_XFER, GAP, DELAY, DONE, VOL_ISSUE, VOL_WAIT, ERROR
    } state_t;

    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = 16'h1E00;
            4'd1:    table_word = 16'h0C10;
            4'd2:    table_word = 16'h0017;
            4'd3:    table_word = 16'h0217;
            4'd4:    table_word = 16'h0479;
            4'd5:    table_word = 16'h0679;
            4'd6:    table_word = 16'h0812;
            4'd7:    table_word = 16'h0A00;
            4'd8:    table_word = 16'h0E02;
            4'd9:    table_word = 16'h1000;
            4'd10:   table_word = 16'h1201;
            default: table_word = 16'h0000;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [15:0]          data_q, data_d;
    logic [3:0]           idx_q, idx_d, idx_next;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 acked_q, acked_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 vol_act_q, vol_act_d;  // current transfer is a volume write
    logic                 pend_q, pend_d;
    logic [6:0]           vol_q, vol_d;
    logic                 start_ok;

    assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        idx_d     = idx_q;
        idx_next  = idx_q + {3'b000, acked_q};
        retry_d   = retry_q;
        acked_d   = acked_q;
        dly_d     = dly_q;
        done_d    = done_q;
        err_d     = err_q;
        vol_act_d = vol_act_q;
        pend_d    = pend_q;
        vol_d     = vol_q;

        if (vol_update) begin
            vol_d  = volume;
            pend_d = 1'b1;
        end

        if (start_ok) begin
            state_d   = ISSUE;
            req_d     = 1'b1;
            data_d    = table_word(4'd0);
            idx_d     = 4'd0;
            retry_d   = '0;
            acked_d   = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            vol_act_d = 1'b0;
            pend_d    = 1'b0;
        end else begin
            case (state_q)
                ISSUE:     state_d = WAIT_XFER;
                VOL_ISSUE: state_d = VOL_WAIT;

                WAIT_XFER, VOL_WAIT: begin
                    if (i2c_done) begin
                        req_d = 1'b0;
                        if (!i2c_nack) begin
                            retry_d = '0;
                            acked_d = 1'b1;
                            if (vol_act_q) begin
                                state_d   = DONE;
                                vol_act_d = 1'b0;
                            end else if (idx_q == 4'd0) begin
                                state_d = DELAY;
                                dly_d   = DLY_W'(POST_RESET_DLY - 1);
                            end else if (idx_q == LAST_INDEX) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = GAP;
                            end
                        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            acked_d = 1'b0;
                            state_d = GAP;
                        end else begin
                            state_d   = ERROR;
                            err_d     = 1'b1;
                            done_d    = 1'b0;
                            vol_act_d = 1'b0;
                        end
                    end
                end

                // Retries of a volume write pass through here too; its word is still in data_q.
                GAP: begin
                    req_d = 1'b1;
                    if (vol_act_q) begin
                        state_d = VOL_ISSUE;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_next;
                        data_d  = table_word(idx_next);
                    end
                end

                DELAY: begin
                    if (dly_q == '0) begin
                        state_d = ISSUE;
                        req_d   = 1'b1;
                        idx_d   = 4'd1;
                        data_d  = table_word(4'd1);
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end

                DONE: begin
                    if (pend_q) begin
                        state_d   = VOL_ISSUE;
                        req_d     = 1'b1;
                        data_d    = VOL_BASE | {9'b0, vol_q};
                        retry_d   = '0;
                        vol_act_d = 1'b1;
                        pend_d    = vol_update;  // a fresh pulse this cycle stays queued
                    end
                end

                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            acked_q   <= 1'b0;
            dly_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            vol_act_q <= 1'b0;
            pend_q    <= 1'b0;
            vol_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            acked_q   <= acked_d;
            dly_q     <= dly_d;
            done_q    <= done_d;
            err_q     <= err_d;
            vol_act_q <= vol_act_d;
            pend_q    <= pend_d;
            vol_q     <= vol_d;
        end
    end

    assign i2c_req   = req_q;
    assign i2c_addr  = DEV_ADDR;
    assign i2c_data  = data_q;
    assign reg_index = idx_q;
    assign done      = done_q;
    assign error     = err_q;
    assign busy      = !(state_q == IDLE || state_q == DONE || state_q == ERROR);

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: an I2C master model with random ack latency and
// scripted NACKs, checked against the expected word sequence built from the table.
module tb_codec_init_sequencer;

    localparam int MAX_RETRY      = 3;
    localparam int POST_RESET_DLY = 1000;

    logic        clk = 1'b0;
    logic        reset, start, vol_update;
    logic [6:0]  volume;
    logic        i2c_req, i2c_done, i2c_nack;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic        busy, done, error;
    logic [3:0]  reg_index;

    codec_init_sequencer #(
        .DEV_ADDR      (7'h1A),
        .MAX_RETRY     (MAX_RETRY),
        .POST_RESET_DLY(POST_RESET_DLY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vol_update(vol_update),
        .volume    (volume),
        .i2c_req   (i2c_req),
        .i2c_addr  (i2c_addr),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .reg_index (reg_index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    logic [15:0] tbl [0:10] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479,
                                16'h0679, 16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

    logic [15:0] xfers[$];     // words seen at the start of each request
    logic [6:0]  addr_log[$];
    logic [1:0]  flag_log[$];  // {busy, done} at the start of each request
    int          gaps[$];      // low cycles of i2c_req before each request
    logic [15:0] exp_q[$];
    int          hold_err = 0;

    int nack_idx   = -1;
    int nack_limit = 0;
    int nack_used  = 0;

    wire [30:0] out_vec    = {i2c_req, i2c_data, reg_index, busy, done, error, i2c_addr};
    wire [30:0] idle_vec   = {1'b0, 16'h0000, 4'h0, 3'b000, 7'h1A};

    // I2C master model: acks (or NACKs per policy) after a random latency.
    initial begin
        logic [15:0] cur;
        int          lat;
        bit          aborted;
        bit          nk;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_req && !reset) begin
                cur = i2c_data;
                xfers.push_back(cur);
                addr_log.push_back(i2c_addr);
                flag_log.push_back({busy, done});
                lat = $urandom_range(2, 24);
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!i2c_req || i2c_data !== cur) hold_err++;
                end
                if (!aborted) begin
                    nk = (nack_idx >= 0) && (cur == tbl[nack_idx]) && (nack_used < nack_limit);
                    if (nk) nack_used++;
                    i2c_done = 1'b1;
                    i2c_nack = nk;
                    @(negedge clk);
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    // Request-gap monitor.
    initial begin
        int  low_run = 0;
        bit  prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_req) begin
                if (!prev) gaps.push_back(low_run);
                low_run = 0;
            end else begin
                low_run++;
            end
            prev = i2c_req;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- model and stimulus helpers ----------------
    bit exp_fail;

    // Expected init word sequence: each word once, the NACKed word repeated per
    // its NACK count, truncated at MAX_RETRY+1 attempts when retries run out.
    task automatic build_init(input int nidx, input int nlim);
        exp_q.delete();
        exp_fail = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i == nidx) begin
                if (nlim > MAX_RETRY) begin
                    for (int r = 0; r <= MAX_RETRY; r++) exp_q.push_back(tbl[i]);
                    exp_fail = 1'b1;
                    return;
                end
                for (int r = 0; r < nlim; r++) exp_q.push_back(tbl[i]);
            end
            exp_q.push_back(tbl[i]);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (xfers.size() < exp_q.size()) ? xfers.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (xfers[i] !== exp_q[i]) return i;
        if (xfers.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [15:0] got_at(input int i);
        return (i >= 0 && i < xfers.size()) ? xfers[i] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 16'hxxxx;
    endfunction

    task automatic clear_logs();
        xfers.delete();
        addr_log.delete();
        flag_log.delete();
        gaps.delete();
        hold_err  = 0;
        nack_used = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_vol(input logic [6:0] v);
        @(posedge clk); #1 vol_update = 1'b1; volume = v;
        @(posedge clk); #1 vol_update = 1'b0;
    endtask

    // Waits for n transfers and an idle finish (done or error); expiry counts as a failure.
    task automatic settle(input int n_xfer, input string tag);
        int k;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (xfers.size() >= n_xfer && !busy && (done || error)) break;
        end
        n_checks++;
        if (k == 6000) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d transfers busy=%b, required %0d transfers then idle",
                     tag, xfers.size(), busy, n_xfer);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; vol_update = 1'b0; volume = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_vec !== idle_vec) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required %h", out_vec, idle_vec);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_vec !== idle_vec) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h required %h", out_vec, idle_vec);
        end
    endtask

    task automatic test_nominal();
        int d;
        int bad_addr;
        clear_logs();
        nack_idx = -1;
        build_init(-1, 0);
        pulse_start();
        @(negedge clk);
        n_checks++;
        if ({i2c_req, i2c_data, busy} !== {1'b1, 16'h1E00, 1'b1}) begin
            n_bad++;
            $display("FAIL first_req: got req=%b data=%h busy=%b required req=1 data=1e00 busy=1",
                     i2c_req, i2c_data, busy);
        end
        settle(11, "nominal");
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL nominal_seq: at %0d got %h (%0d words) required %h (%0d words)",
                     d, got_at(d), xfers.size(), exp_at(d), exp_q.size());
        end
        bad_addr = 0;
        foreach (addr_log[i]) if (addr_log[i] !== 7'h1A) bad_addr++;
        n_checks++;
        if (bad_addr != 0 || addr_log.size() == 0) begin
            n_bad++;
            $display("FAIL i2c_addr: got %0d wrong of %0d required all 1a", bad_addr, addr_log.size());
        end
        n_checks++;
        if (gaps.size() < 2 || gaps[1] < POST_RESET_DLY) begin
            n_bad++;
            $display("FAIL post_reset_delay: got %0d idle cycles required >= %0d",
                     (gaps.size() < 2) ? -1 : gaps[1], POST_RESET_DLY);
        end
        n_checks++;
        if ({done, busy, error, reg_index} !== {3'b100, 4'd10}) begin
            n_bad++;
            $display("FAIL nominal_end: got done=%b busy=%b error=%b idx=%0d required 1 0 0 10",
                     done, busy, error, reg_index);
        end
        n_checks++;
        if (hold_err != 0) begin
            n_bad++;
            $display("FAIL req_hold: got %0d unstable cycles required 0", hold_err);
        end
    endtask

    task automatic test_nack_recovery();
        int d;
        int bad_gap;
        for (int it = 0; it < 2; it++) begin
            clear_logs();
            nack_idx   = (it == 0) ? 3 : $urandom_range(1, 10);
            nack_limit = (it == 0) ? 2 : $urandom_range(1, MAX_RETRY);
            build_init(nack_idx, nack_limit);
            pulse_start();
            settle(exp_q.size(), "nack");
            d = first_diff();
            n_checks++;
            if (d != -1) begin
                n_bad++;
                $display("FAIL nack_seq idx=%0d n=%0d: at %0d got %h required %h",
                         nack_idx, nack_limit, d, got_at(d), exp_at(d));
            end
            bad_gap = 0;
            for (int i = 1; i < exp_q.size() && i < gaps.size(); i++)
                if (exp_q[i] == exp_q[i-1] && gaps[i] != 1) bad_gap++;
            n_checks++;
            if (bad_gap != 0) begin
                n_bad++;
                $display("FAIL retry_gap: got %0d retries without a 1-cycle gap required 0", bad_gap);
            end
            n_checks++;
            if ({done, error, busy, hold_err == 0} !== 4'b1001) begin
                n_bad++;
                $display("FAIL nack_end: got done=%b error=%b busy=%b hold_err=%0d required 1 0 0 0",
                         done, error, busy, hold_err);
            end
        end
        nack_idx = -1;
    endtask

    task automatic test_retry_exhaust();
        int d;
        for (int it = 0; it < 2; it++) begin
            clear_logs();
            nack_idx   = (it == 0) ? 5 : $urandom_range(1, 10);
            nack_limit = 1000;
            build_init(nack_idx, nack_limit);
            pulse_start();
            settle(exp_q.size(), "exhaust");
            d = first_diff();
            n_checks++;
            if (d != -1 || !exp_fail) begin
                n_bad++;
                $display("FAIL exhaust_seq idx=%0d: at %0d got %h required %h",
                         nack_idx, d, got_at(d), exp_at(d));
            end
            n_checks++;
            if ({error, done, busy, i2c_req, reg_index} !== {4'b1000, 4'(nack_idx)}) begin
                n_bad++;
                $display("FAIL exhaust_state: got err=%b done=%b busy=%b req=%b idx=%0d required 1 0 0 0 %0d",
                         error, done, busy, i2c_req, reg_index, nack_idx);
            end
            // A fresh start must clear the error and run the whole table again.
            clear_logs();
            nack_idx = -1;
            build_init(-1, 0);
            pulse_start();
            @(negedge clk);
            n_checks++;
            if ({error, i2c_req, i2c_data} !== {1'b0, 1'b1, 16'h1E00}) begin
                n_bad++;
                $display("FAIL restart: got err=%b req=%b data=%h required 0 1 1e00",
                         error, i2c_req, i2c_data);
            end
            settle(11, "restart");
            d = first_diff();
            n_checks++;
            if (d != -1 || done !== 1'b1) begin
                n_bad++;
                $display("FAIL restart_seq: at %0d got %h done=%b required %h done=1",
                         d, got_at(d), done, exp_at(d));
            end
        end
    endtask

    task automatic test_volume();
        logic [6:0]  v;
        logic [15:0] w;
        for (int it = 0; it < 3; it++) begin
            v = (it == 0) ? 7'h60 : 7'($urandom_range(0, 127));
            w = 16'h0500 | {9'b0, v};
            clear_logs();
            pulse_vol(v);
            settle(1, "volume");
            n_checks++;
            if (xfers.size() != 1 || xfers[0] !== w) begin
                n_bad++;
                $display("FAIL vol_word: got %h (%0d words) required %h (1 word)",
                         got_at(0), xfers.size(), w);
            end
            n_checks++;
            if (flag_log.size() != 1 || flag_log[0] !== 2'b11) begin
                n_bad++;
                $display("FAIL vol_flags: got busy,done=%b required 11",
                         (flag_log.size() > 0) ? flag_log[0] : 2'bxx);
            end
            n_checks++;
            if ({done, busy, error} !== 3'b100) begin
                n_bad++;
                $display("FAIL vol_end: got done=%b busy=%b error=%b required 1 0 0", done, busy, error);
            end
        end
    endtask

    task automatic test_vol_during_init();
        logic [6:0] v1, v2;
        int d;
        int k;
        v1 = 7'h30;
        v2 = 7'h45 ^ 7'($urandom_range(0, 1) << 3);
        clear_logs();
        build_init(-1, 0);
        exp_q.push_back(16'h0500 | {9'b0, v2});
        pulse_start();
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (reg_index == 4'd4) break;
        end
        n_checks++;
        if (k == 3000) begin
            n_bad++;
            $display("FAIL reach_index4: got idx=%0d required 4 within 3000 cycles", reg_index);
        end
        pulse_vol(v1);
        pulse_vol(v2);
        settle(12, "vol_init");
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL vol_init_seq: at %0d got %h (%0d words) required %h (%0d words)",
                     d, got_at(d), xfers.size(), exp_at(d), exp_q.size());
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (xfers.size() != 12 || {done, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL vol_init_extra: got %0d words done=%b busy=%b required 12 1 0",
                     xfers.size(), done, busy);
        end
    endtask

    task automatic test_start_vol_collide();
        int d;
        clear_logs();
        build_init(-1, 0);
        @(posedge clk); #1 start = 1'b1; vol_update = 1'b1; volume = 7'($urandom_range(0, 127));
        @(posedge clk); #1 start = 1'b0; vol_update = 1'b0;
        settle(11, "collide");
        repeat (40) @(negedge clk);
        d = first_diff();
        n_checks++;
        if (d != -1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_seq: at %0d got %h (%0d words) busy=%b required %h (11 words) busy=0",
                     d, got_at(d), xfers.size(), busy, exp_at(d));
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_logs();
        pulse_start();
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (i2c_req) break;
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_vec !== idle_vec) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h required %h", out_vec, idle_vec);
        end
        repeat (100) @(negedge clk);
        n_checks++;
        if (xfers.size() != 1 || {i2c_req, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: got %0d words req=%b busy=%b required 1 0 0",
                     xfers.size(), i2c_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_nack_recovery();
        test_retry_exhaust();
        test_volume();
        test_vol_during_init();
        test_start_vol_collide();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
